// File: rtl/edge_row_packer_if.sv
// Row-word interface of the edge row packer.
// Carries the serial edge stream into the packer and the packed row words out of it.
// master: the packer itself. slave: the surrounding logic that feeds edges and drains rows.
interface edge_row_packer_if #(
  parameter int unsigned ROW_W = 18,
  parameter int unsigned IDX_W = 5
);
  logic             edge_in;
  logic             edge_valid;
  logic [ROW_W-1:0] row_word;
  logic [IDX_W-1:0] row_idx;
  logic             row_valid;
  logic             row_ready;
  logic             frame_done;
  logic             overflow;

  modport master (
    input  edge_in,
    input  edge_valid,
    input  row_ready,
    output row_word,
    output row_idx,
    output row_valid,
    output frame_done,
    output overflow
  );

  modport slave (
    output edge_in,
    output edge_valid,
    output row_ready,
    input  row_word,
    input  row_idx,
    input  row_valid,
    input  frame_done,
    input  overflow
  );
endinterface

// File: rtl/edge_row_packer.sv
// Edge row packer.
// Collects the serial 1-bit edge stream into one word per image row and tags each word
// with its row number. Words are queued in a small FIFO and handed out over a
// valid/ready handshake. Rows that find the FIFO full are dropped and flagged with a
// sticky overflow. A one-cycle frame_done pulse marks the last row of a frame leaving
// the block, whether it was handed out or dropped.
module edge_row_packer #(
  parameter int unsigned ROW_W      = 18,
  parameter int unsigned ROWS       = 18,
  parameter int unsigned FIFO_DEPTH = 4,   // must be a power of two, at least 2
  parameter int unsigned IDX_W      = 5
) (
  input  logic                clk,
  input  logic                reset,
  edge_row_packer_if.master   bus
);

  localparam int unsigned BitW = $clog2(ROW_W);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [BitW-1:0]  LastBit  = BitW'(ROW_W - 1);
  localparam logic [IDX_W-1:0] LastRow  = IDX_W'(ROWS - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(FIFO_DEPTH);

  // Row assembly state
  logic [BitW-1:0]  bit_cnt;
  logic [IDX_W-1:0] row_cnt;
  logic [ROW_W-1:0] shreg;
  logic [ROW_W-1:0] shreg_next;

  // FIFO storage and bookkeeping
  logic [ROW_W-1:0] word_mem [FIFO_DEPTH];
  logic [IDX_W-1:0] idx_mem  [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;

  logic overflow_q;
  logic frame_done_q;

  logic row_end;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic drop;

  // Current row contents with this cycle's bit merged in; this is what gets pushed.
  always_comb begin
    shreg_next = shreg;
    if (bus.edge_valid) begin
      shreg_next[bit_cnt] = bus.edge_in;
    end
  end

  assign row_end    = bus.edge_valid && (bit_cnt == LastBit);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FullCnt);
  assign pop        = !fifo_empty && bus.row_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push       = row_end && (!fifo_full || pop);
  assign drop       = row_end && !push;

  // Counters, shift register, FIFO and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt      <= '0;
      row_cnt      <= '0;
      shreg        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.edge_valid) begin
        if (row_end) begin
          bit_cnt <= '0;
          shreg   <= '0;
          // Row index advances even for a dropped row so later indices stay correct.
          row_cnt <= (row_cnt == LastRow) ? '0 : row_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shreg   <= shreg_next;
        end
      end

      if (push) begin
        word_mem[wr_ptr] <= shreg_next;
        idx_mem[wr_ptr]  <= row_cnt;
        wr_ptr           <= wr_ptr + 1'b1;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (drop) begin
        overflow_q <= 1'b1;
      end

      frame_done_q <= (pop && (idx_mem[rd_ptr] == LastRow)) ||
                      (drop && (row_cnt == LastRow));
    end
  end

  // Head of the FIFO is shown only while valid so idle outputs read as zero.
  assign bus.row_valid  = !fifo_empty;
  assign bus.row_word   = fifo_empty ? '0 : word_mem[rd_ptr];
  assign bus.row_idx    = fifo_empty ? '0 : idx_mem[rd_ptr];
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_edge_row_packer.sv
// Directed testbench for edge_row_packer.
// Walks through reset, single and gapped rows, backpressure with overflow, a full frame
// and a mid-row reset, checking outputs against hand-computed values.
module tb_edge_row_packer;

  localparam int unsigned ROW_W = 18;
  localparam int unsigned IDX_W = 5;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  edge_row_packer_if #(.ROW_W(ROW_W), .IDX_W(IDX_W)) bus ();

  edge_row_packer #(
    .ROW_W      (ROW_W),
    .ROWS       (18),
    .FIFO_DEPTH (4),
    .IDX_W      (IDX_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Feed bits lo..hi of w, LSB first; gapped inserts an idle cycle before each bit.
  task automatic send_bits(input logic [ROW_W-1:0] w, input int lo, input int hi,
                           input bit gapped);
    for (int k = lo; k <= hi; k++) begin
      if (gapped) begin
        bus.edge_valid = 1'b0;
        tick();
      end
      bus.edge_in    = w[k];
      bus.edge_valid = 1'b1;
      tick();
    end
    bus.edge_valid = 1'b0;
    bus.edge_in    = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  function automatic logic [ROW_W-1:0] frame_word(input int r);
    logic [4:0] v;
    v = r[4:0];
    return {v, v, v, v[2:0]};
  endfunction

  initial begin
    logic [ROW_W-1:0] alt;
    logic [ROW_W-1:0] ones;
    logic [ROW_W-1:0] zeros;
    checks   = 0;
    failures = 0;
    alt      = 18'h15555;
    ones     = 18'h3FFFF;
    zeros    = 18'h00000;

    reset          = 1'b1;
    bus.edge_in    = 1'b1;
    bus.edge_valid = 1'b1;
    bus.row_ready  = 1'b0;

    // Reset held two cycles with valid input present
    tick();
    tick();
    chk("rst_valid", 32'(bus.row_valid), 32'd0);
    chk("rst_word", 32'(bus.row_word), 32'd0);
    chk("rst_idx", 32'(bus.row_idx), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    reset          = 1'b0;
    bus.edge_valid = 1'b0;
    bus.edge_in    = 1'b0;
    tick();
    chk("rst_noword", 32'(bus.row_valid), 32'd0);

    // Single back-to-back row, consumer always ready
    bus.row_ready = 1'b1;
    send_bits(alt, 0, 16, 1'b0);
    chk("single_early", 32'(bus.row_valid), 32'd0);
    send_bits(alt, 17, 17, 1'b0);
    chk("single_valid", 32'(bus.row_valid), 32'd1);
    chk("single_word", 32'(bus.row_word), 32'h15555);
    chk("single_idx", 32'(bus.row_idx), 32'd0);
    tick();
    chk("single_clr", 32'(bus.row_valid), 32'd0);

    // Same row with idle cycles between bits
    send_bits(alt, 0, 16, 1'b1);
    tick();
    chk("gap_early", 32'(bus.row_valid), 32'd0);
    send_bits(alt, 17, 17, 1'b1);
    chk("gap_valid", 32'(bus.row_valid), 32'd1);
    chk("gap_word", 32'(bus.row_word), 32'h15555);
    chk("gap_idx", 32'(bus.row_idx), 32'd1);
    tick();
    chk("gap_clr", 32'(bus.row_valid), 32'd0);

    // Backpressure: four rows fill the FIFO, the fifth is dropped
    do_reset(1);
    bus.row_ready = 1'b0;
    for (int r = 0; r < 4; r++) send_bits(ones, 0, 17, 1'b0);
    chk("bp_full_ovf", 32'(bus.overflow), 32'd0);
    chk("bp_full_valid", 32'(bus.row_valid), 32'd1);
    send_bits(ones, 0, 17, 1'b0);
    chk("bp_ovf", 32'(bus.overflow), 32'd1);
    chk("bp_head_idx", 32'(bus.row_idx), 32'd0);
    chk("bp_head_stable", 32'(bus.row_word), 32'h3FFFF);
    bus.row_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_drain_valid%0d", i), 32'(bus.row_valid), 32'd1);
      chk($sformatf("bp_drain_idx%0d", i), 32'(bus.row_idx), 32'(i));
      chk($sformatf("bp_drain_word%0d", i), 32'(bus.row_word), 32'h3FFFF);
      tick();
    end
    chk("bp_empty", 32'(bus.row_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(bus.overflow), 32'd1);
    send_bits(zeros, 0, 17, 1'b0);
    chk("bp_next_idx", 32'(bus.row_idx), 32'd5);
    chk("bp_next_word", 32'(bus.row_word), 32'd0);
    tick();

    // Full frame of 18 rows, frame_done after the last handshake only
    do_reset(1);
    chk("frame_ovf_clr", 32'(bus.overflow), 32'd0);
    bus.row_ready = 1'b1;
    for (int r = 0; r < 18; r++) begin
      send_bits(frame_word(r), 0, 17, 1'b0);
      chk($sformatf("frame_valid%0d", r), 32'(bus.row_valid), 32'd1);
      chk($sformatf("frame_idx%0d", r), 32'(bus.row_idx), 32'(r));
      chk($sformatf("frame_word%0d", r), 32'(bus.row_word), 32'(frame_word(r)));
      chk($sformatf("frame_done_pre%0d", r), 32'(bus.frame_done), 32'd0);
      tick();
      chk($sformatf("frame_done_post%0d", r), 32'(bus.frame_done), (r == 17) ? 32'd1 : 32'd0);
    end
    tick();
    chk("frame_done_pulse", 32'(bus.frame_done), 32'd0);
    send_bits(zeros, 0, 17, 1'b0);
    chk("frame_wrap_idx", 32'(bus.row_idx), 32'd0);
    chk("frame_wrap_valid", 32'(bus.row_valid), 32'd1);
    tick();

    // Reset in the middle of a row discards the partial bits
    bus.row_ready  = 1'b1;
    bus.edge_in    = 1'b1;
    bus.edge_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    do_reset(1);
    send_bits(zeros, 0, 17, 1'b0);
    chk("midrst_valid", 32'(bus.row_valid), 32'd1);
    chk("midrst_word", 32'(bus.row_word), 32'd0);
    chk("midrst_idx", 32'(bus.row_idx), 32'd0);
    chk("midrst_ovf", 32'(bus.overflow), 32'd0);
    tick();
    chk("midrst_clr", 32'(bus.row_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
